fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter that lets NREQ producers share one FIFO write
//   port. Each grant lasts until the owner has written BURST_MAX beats or
//   drops its valid. Every grant costs one idle arbitration cycle.
//
// Ports
//   clk         in   clock, all state on the rising edge
//   rst         in   asynchronous, active-high reset
//   req_valid   in   [NREQ]      per-producer data valid
//   req_data    in   [NREQ*DW]   producer i data in bits [i*DW +: DW]
//   req_ready   out  [NREQ]      per-producer accept (owner only)
//   fifo_full   in               shared FIFO full flag (stalls the owner)
//   fifo_wr_en  out              FIFO write strobe
//   fifo_wdata  out  [DW]        FIFO write data (0 when idle)
//   grant_id    out  [clog2(NREQ)] current owner, 0 when idle
//   busy        out              a producer owns the FIFO
//   beat_cnt    out  [16]        accepted beats since reset (wraps)
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DW-1:0]             fifo_wdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic [15:0]               beat_cnt
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [4:0]      burst_q, burst_d;
  logic [15:0]     beat_cnt_q, beat_cnt_d;
  logic            busy_q;
  logic [IW-1:0]   grant_q;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            owner_valid;
  logic            transfer;
  logic            burst_last;
  logic [IW-1:0]   owner_next;

  // First valid requester searching upward from rr_ptr with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_ptr_q) + k) % 32'(NREQ));
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign transfer    = (state_q == OWN) && owner_valid && !fifo_full;
  assign burst_last  = (burst_q == 5'(BURST_MAX - 1));
  assign owner_next  = IW'((32'(owner_q) + 32'd1) % 32'(NREQ));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          burst_d = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        // A full FIFO only stalls; ownership is lost solely by the owner
        // dropping valid or by completing the last beat of the burst.
        if (transfer) begin
          burst_d    = burst_q + 5'd1;
          beat_cnt_d = beat_cnt_q + 16'd1;
        end
        if (!owner_valid || (transfer && burst_last)) begin
          state_d  = IDLE;
          rr_ptr_d = owner_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // busy/grant_id are registered from the next state so they change in
  // lockstep with state_q without adding a decode path to the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= (state_d == OWN);
      grant_q    <= (state_d == OWN) ? owner_d : '0;
    end
  end

  always_comb begin
    req_ready  = '0;
    fifo_wdata = '0;
    if (state_q == OWN) begin
      req_ready[owner_q] = !fifo_full;
      fifo_wdata         = req_data[32'(owner_q) * DW +: DW];
    end
  end

  assign fifo_wr_en = transfer;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter. Producers are modelled as data
//   queues; every beat offered is also pushed to a per-producer expected
//   queue, and a monitor pops and compares on every FIFO write. Directed
//   scenarios additionally compare a per-cycle output trace to hand-written
//   tables.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int BURST_MAX = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [DW-1:0]        fifo_wdata;
  logic [1:0]           grant_id;
  logic                 busy;
  logic [15:0]          beat_cnt;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        busy;
    logic [1:0]  gid;
    logic [7:0]  data;
    logic [3:0]  rdy;
    logic [15:0] bcnt;
  } trace_t;

  trace_t     trace[$];
  trace_t     expt[$];
  logic [7:0] src_q[NREQ][$];
  logic [7:0] exp_q[NREQ][$];
  logic [3:0] en;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         burst_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic e(input logic wr, input logic bsy, input logic [1:0] gid,
                   input logic [7:0] data, input logic [3:0] rdy);
    trace_t t;
    t.wr = wr; t.busy = bsy; t.gid = gid; t.data = data; t.rdy = rdy; t.bcnt = '0;
    expt.push_back(t);
  endtask

  task automatic push_beat(input int p, input logic [7:0] d);
    src_q[p].push_back(d);
    exp_q[p].push_back(d);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++)
      if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive at negedge, record settled outputs, retire handshakes.
  task automatic cycle(input logic full);
    trace_t t;
    @(negedge clk);
    fifo_full = full;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && (src_q[i].size() != 0);
      req_data[i*DW +: DW] = req_valid[i] ? src_q[i][0] : 8'h00;
    end
    #1;
    t.wr = fifo_wr_en; t.busy = busy; t.gid = grant_id;
    t.data = fifo_wdata; t.rdy = req_ready; t.bcnt = beat_cnt;
    trace.push_back(t);
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
  endtask

  task automatic check_trace(input string name);
    chk({name, " length"}, trace.size(), expt.size());
    for (int k = 0; k < expt.size() && k < trace.size(); k++) begin
      chk($sformatf("%s c%0d wr_en", name, k),  trace[k].wr,   expt[k].wr);
      chk($sformatf("%s c%0d busy", name, k),   trace[k].busy, expt[k].busy);
      chk($sformatf("%s c%0d grant", name, k),  trace[k].gid,  expt[k].gid);
      chk($sformatf("%s c%0d wdata", name, k),  trace[k].data, expt[k].data);
      chk($sformatf("%s c%0d ready", name, k),  trace[k].rdy,  expt[k].rdy);
    end
    trace.delete();
    expt.delete();
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0; en = '0;
    flush();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    trace.delete();
    expt.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, " wr_en"},  fifo_wr_en, 0);
    chk({name, " busy"},   busy, 0);
    chk({name, " grant"},  grant_id, 0);
    chk({name, " ready"},  req_ready, 0);
    chk({name, " wdata"},  fifo_wdata, 0);
    chk({name, " beat_cnt"}, beat_cnt, 0);
  endtask

  // Scoreboard monitor: every write must be the oldest outstanding beat of
  // the granted producer, and no ownership may carry more than BURST_MAX.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      burst_run = 0;
    end else begin
      if (fifo_wr_en) begin
        burst_run++;
        chk("burst length", burst_run <= BURST_MAX, 1);
        if (exp_q[grant_id].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected write p%0d: got 0x%0h, expected no write", grant_id, fifo_wdata);
        end else begin
          chk($sformatf("data p%0d", grant_id), fifo_wdata, exp_q[grant_id].pop_front());
        end
      end
      if (!busy) burst_run = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running, expected finished");
    $fatal(1, "time limit reached");
  end

  initial begin
    int budget;
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0; en = '0;
    #1;
    check_outputs_zero("reset");

    // Single producer: burst of 4, re-arbitration, tail of 2.
    do_reset();
    for (int k = 0; k < 6; k++) push_beat(0, 8'(8'h11 + k));
    en = 4'b0001;
    repeat (10) cycle(1'b0);
    chk("A beat_cnt", beat_cnt, 6);
    e(0, 0, 0, 8'h00, 4'b0000);
    for (int k = 0; k < 4; k++) e(1, 1, 0, 8'(8'h11 + k), 4'b0001);
    e(0, 0, 0, 8'h00, 4'b0000);
    e(1, 1, 0, 8'h15, 4'b0001);
    e(1, 1, 0, 8'h16, 4'b0001);
    e(0, 1, 0, 8'h00, 4'b0001);
    e(0, 0, 0, 8'h00, 4'b0000);
    check_trace("A");

    // All four continuously valid: grants rotate 0,1,2,3,0,1,2,3.
    do_reset();
    for (int p = 0; p < NREQ; p++)
      for (int k = 0; k < 8; k++) push_beat(p, 8'((p << 4) | k));
    en = 4'b1111;
    repeat (41) cycle(1'b0);
    chk("B beat_cnt after 4 bursts", trace[20].bcnt, 16);
    chk("B beat_cnt final", beat_cnt, 32);
    for (int b = 0; b < 8; b++) begin
      e(0, 0, 0, 8'h00, 4'b0000);
      for (int j = 0; j < 4; j++)
        e(1, 1, 2'(b % 4), 8'(((b % 4) << 4) | ((b / 4) * 4 + j)), 4'(1 << (b % 4)));
    end
    e(0, 0, 0, 8'h00, 4'b0000);
    check_trace("B");

    // Producer 2 stalled by fifo_full for 3 cycles mid-burst.
    do_reset();
    for (int k = 0; k < 4; k++) push_beat(2, 8'(8'h21 + k));
    en = 4'b0100;
    for (int c = 0; c < 9; c++) cycle(c >= 3 && c <= 5);
    chk("C beat_cnt", beat_cnt, 4);
    e(0, 0, 0, 8'h00, 4'b0000);
    e(1, 1, 2, 8'h21, 4'b0100);
    e(1, 1, 2, 8'h22, 4'b0100);
    repeat (3) e(0, 1, 2, 8'h23, 4'b0000);
    e(1, 1, 2, 8'h23, 4'b0100);
    e(1, 1, 2, 8'h24, 4'b0100);
    e(0, 0, 0, 8'h00, 4'b0000);
    check_trace("C");

    // Producer 1 drops valid after 2 beats; 3 is next, then 1 resumes.
    do_reset();
    for (int k = 0; k < 4; k++) push_beat(1, 8'(8'h10 + k));
    for (int k = 0; k < 4; k++) push_beat(3, 8'(8'h30 + k));
    en = 4'b1010;
    repeat (3) cycle(1'b0);
    en[1] = 1'b0;
    repeat (6) cycle(1'b0);
    en[1] = 1'b1;
    repeat (5) cycle(1'b0);
    chk("D beats credited to p1", trace[4].bcnt, 2);
    chk("D beat_cnt", beat_cnt, 8);
    e(0, 0, 0, 8'h00, 4'b0000);
    e(1, 1, 1, 8'h10, 4'b0010);
    e(1, 1, 1, 8'h11, 4'b0010);
    e(0, 1, 1, 8'h00, 4'b0010);
    e(0, 0, 0, 8'h00, 4'b0000);
    for (int k = 0; k < 4; k++) e(1, 1, 3, 8'(8'h30 + k), 4'b1000);
    e(0, 0, 0, 8'h00, 4'b0000);
    e(1, 1, 1, 8'h12, 4'b0010);
    e(1, 1, 1, 8'h13, 4'b0010);
    e(0, 1, 1, 8'h00, 4'b0010);
    e(0, 0, 0, 8'h00, 4'b0000);
    check_trace("D");

    // Reset during beat 3 of producer 3, then arbitration restarts at 0.
    do_reset();
    for (int k = 0; k < 4; k++) push_beat(3, 8'(8'h30 + k));
    en = 4'b1000;
    repeat (4) cycle(1'b0);
    e(0, 0, 0, 8'h00, 4'b0000);
    for (int k = 0; k < 3; k++) e(1, 1, 3, 8'(8'h30 + k), 4'b1000);
    check_trace("E pre");
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("E async reset");
    req_valid = '0; req_data = '0; en = '0;
    flush();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    trace.delete();
    push_beat(1, 8'h1A);
    push_beat(1, 8'h1B);
    push_beat(3, 8'h3A);
    en = 4'b1010;
    repeat (8) cycle(1'b0);
    chk("E beat_cnt", beat_cnt, 3);
    e(0, 0, 0, 8'h00, 4'b0000);
    e(1, 1, 1, 8'h1A, 4'b0010);
    e(1, 1, 1, 8'h1B, 4'b0010);
    e(0, 1, 1, 8'h00, 4'b0010);
    e(0, 0, 0, 8'h00, 4'b0000);
    e(1, 1, 3, 8'h3A, 4'b1000);
    e(0, 1, 3, 8'h00, 4'b1000);
    e(0, 0, 0, 8'h00, 4'b0000);
    check_trace("E post");

    // 1000 beats, random valid drops and random fifo_full.
    do_reset();
    for (int p = 0; p < NREQ; p++)
      for (int k = 0; k < 250; k++) push_beat(p, 8'((p << 6) | (k % 64)));
    budget = 0;
    while (pending() && budget < 20000) begin
      for (int i = 0; i < NREQ; i++) en[i] = ($urandom_range(0, 9) != 0);
      cycle($urandom_range(0, 3) == 0);
      trace.delete();
      budget++;
    end
    chk("F drained within budget", budget < 20000, 1);
    en = '0;
    repeat (2) cycle(1'b0);
    trace.delete();
    chk("F beat_cnt", beat_cnt, 1000);
    for (int p = 0; p < NREQ; p++)
      chk($sformatf("F p%0d outstanding beats", p), exp_q[p].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
